mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx.sv | 121 ++++++++++++
 tb/tb_mmio_uart_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with a store-fed byte FIFO
module mmio_uart_tx #(
  parameter logic [31:0] TX_ADDR      = 32'h0000_8000,
  parameter int          CLKS_PER_BIT = 4,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_write,
  input  logic [7:0]  data,
  input  logic [31:0] data_address,
  output logic        tx,
  output logic        busy,
  output logic        overflow,
  output logic [4:0]  fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]    DEPTH     = 5'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [1:0]    state;
  logic [CW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          hit, full, empty, baud_done, pop, push;

  assign hit       = data_write && (data_address == TX_ADDR);
  assign full      = (fifo_count == DEPTH);
  assign empty     = (fifo_count == 5'd0);
  assign baud_done = (baud == BAUD_LAST);
  // The last stop cycle pops directly so consecutive frames have no idle gap.
  assign pop       = !empty && ((state == S_IDLE) || (state == S_STOP && baud_done));
  // A pop at the same edge frees a slot, so a full FIFO still accepts the byte.
  assign push      = hit && (!full || pop);

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= 5'd0;
      overflow   <= 1'b0;
      baud       <= '0;
      bit_idx    <= 3'd0;
      shift      <= 8'hFF;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + {4'd0, push} - {4'd0, pop};
      if (hit && full && !pop) overflow <= 1'b1;

      case (state)
        S_IDLE: begin
          if (pop) begin
            shift <= mem[rd_ptr];
            baud  <= '0;
            state <= S_START;
          end
        end
        S_START: begin
          if (baud_done) begin
            baud    <= '0;
            bit_idx <= 3'd0;
            state   <= S_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud  <= '0;
            shift <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) state <= S_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_done) begin
            baud <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      S_START: tx = 1'b0;
      S_DATA:  tx = shift[0];
      default: tx = 1'b1;
    endcase
  end

  assign busy = (state != S_IDLE) || !empty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - scoreboard bench for mmio_uart_tx against a timing-level FIFO/frame model
module tb_mmio_uart_tx;

  localparam logic [31:0] TXA = 32'h0000_8000;
  localparam int C = 4;
  localparam int D = 8;
  localparam int FRAME = 10 * C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_write = 1'b0;
  logic [7:0]  data = 8'h00;
  logic [31:0] data_address = 32'h0;
  logic        tx, busy, overflow;
  logic [4:0]  fifo_count;

  mmio_uart_tx #(.TX_ADDR(TXA), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .data_write(data_write), .data(data),
    .data_address(data_address), .tx(tx), .busy(busy),
    .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] b; int start; } frame_t;
  frame_t     exp_q[$];
  logic [7:0] mq[$];
  int         free_at = 0;
  bit         m_ovf = 1'b0;
  bit         armed = 1'b0;
  int         peak = 0;
  int         total = 0;
  int         passed = 0;

  task automatic check(input string name, input int act, input int exp_v);
    total++;
    if (act == exp_v) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
  endtask

  task automatic check_status();
    bit mbusy;
    mbusy = (mq.size() != 0) || (cyc < free_at);
    check("fifo_count", int'(fifo_count), mq.size());
    check("busy", int'(busy), int'(mbusy));
    check("overflow", int'(overflow), int'(m_ovf));
    if (!mbusy) check("idle_tx", int'(tx), 1);
  endtask

  // Model of the upcoming edge: the transmitter is free once the previous frame's
  // 10*C cycles have elapsed; a byte written at an edge can be popped from the next edge on.
  task automatic model_edge(input bit hit, input logic [7:0] d, input bit r);
    int  e;
    bit  pop;
    frame_t f;
    e = cyc + 1;
    if (r) begin
      mq.delete();
      exp_q.delete();
      free_at = 0;
      m_ovf = 1'b0;
    end else begin
      pop = (mq.size() != 0) && (e >= free_at);
      if (pop) begin
        f.b = mq.pop_front();
        f.start = e;
        exp_q.push_back(f);
        free_at = e + FRAME;
      end
      if (hit) begin
        if (mq.size() < D) mq.push_back(d);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic step(input bit w, input logic [31:0] a, input logic [7:0] d, input bit r);
    @(negedge clk);
    if (armed) check_status();
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
    data_write = w;
    data_address = a;
    data = d;
    reset = r;
    model_edge(w && (a == TXA), d, r);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 8'h00, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (((mq.size() != 0) || (cyc + 1 < free_at)) && n < 3000) begin
      idle();
      n++;
    end
    repeat (3) idle();
    check("drain_busy", int'(busy), 0);
  endtask

  // Monitor: decodes serial frames cycle by cycle and pops the scoreboard.
  initial begin
    logic samp [FRAME];
    bit   in_frame;
    int   idx, fstart;
    bit   shape_ok;
    logic lvl;
    logic [7:0] got;
    frame_t f;
    in_frame = 1'b0;
    idx = 0;
    fstart = 0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        in_frame = 1'b0;
      end else begin
        if (!in_frame && tx === 1'b0) begin
          in_frame = 1'b1;
          idx = 0;
          fstart = cyc;
        end
        if (in_frame) begin
          samp[idx] = tx;
          idx++;
          if (idx == FRAME) begin
            in_frame = 1'b0;
            shape_ok = 1'b1;
            got = 8'h00;
            for (int s = 0; s < 10; s++) begin
              lvl = samp[s*C + C/2];
              for (int k = 0; k < C; k++) if (samp[s*C + k] !== lvl) shape_ok = 1'b0;
              if (s >= 1 && s <= 8) got[s-1] = lvl;
            end
            check("start_bit", int'(samp[C/2]), 0);
            check("stop_bit", int'(samp[9*C + C/2]), 1);
            check("bit_hold", int'(shape_ok), 1);
            check("frame_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
              f = exp_q.pop_front();
              check("frame_byte", int'(got), int'(f.b));
              check("frame_start_cycle", fstart, f.start);
            end
          end
        end
      end
    end
  end

  initial begin
    int p, rate;
    logic [31:0] a;
    step(1'b0, 32'h0, 8'h00, 1'b1);
    step(1'b1, TXA, 8'h77, 1'b1);
    armed = 1'b1;
    idle();
    idle();

    // Address filter: wrong address, and right address without a strobe.
    step(1'b1, TXA + 32'd1, 8'h55, 1'b0);
    step(1'b0, TXA, 8'h55, 1'b0);
    repeat (6) idle();
    check("filter_count", int'(fifo_count), 0);
    check("filter_tx", int'(tx), 1);

    // Single byte.
    step(1'b1, TXA, 8'hA5, 1'b0);
    drain();

    // Back-to-back, queue peaks at 2.
    peak = 0;
    step(1'b1, TXA, 8'h01, 1'b0);
    step(1'b1, TXA, 8'h02, 1'b0);
    step(1'b1, TXA, 8'h03, 1'b0);
    drain();
    check("b2b_peak", peak, 2);

    // Overflow burst, sticky after transmission ends.
    for (int i = 0; i < 10; i++) step(1'b1, TXA, 8'h10 + 8'(i), 1'b0);
    drain();
    check("ovf_sticky", int'(overflow), 1);
    step(1'b0, 32'h0, 8'h00, 1'b1);
    idle();

    // Full FIFO, write exactly at the edge where STOP completes.
    for (int i = 0; i < 9; i++) step(1'b1, TXA, 8'h40 + 8'(i), 1'b0);
    while (cyc + 2 < free_at) idle();
    step(1'b1, TXA, 8'hC3, 1'b0);
    @(posedge clk);
    #1;
    check("pushpop_count", int'(fifo_count), D);
    check("pushpop_ovf", int'(overflow), 0);
    drain();

    // Reset during data bit 3 of 0xFF with two bytes queued.
    step(1'b1, TXA, 8'hFF, 1'b0);
    step(1'b1, TXA, 8'h11, 1'b0);
    step(1'b1, TXA, 8'h22, 1'b0);
    p = free_at - FRAME;
    while (cyc < p + 4*C + 1) idle();
    step(1'b0, 32'h0, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    check("rst_tx", int'(tx), 1);
    check("rst_count", int'(fifo_count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovf", int'(overflow), 0);
    repeat (60) idle();

    // Randomized traffic with varying write density and rare resets.
    for (int chunk = 0; chunk < 15; chunk++) begin
      rate = $urandom_range(2, 60);
      for (int i = 0; i < 200; i++) begin
        a = ($urandom_range(0, 4) != 0) ? TXA : (TXA ^ (32'd1 << $urandom_range(0, 31)));
        step($urandom_range(0, rate - 1) == 0, a, 8'($urandom_range(0, 255)),
             $urandom_range(0, 799) == 0);
      end
    end
    drain();
    check("pending_frames", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
